accel_seq_ctrl: RTL and testbench
=================================

// Module: accel_seq_ctrl
// PURPOSE
//  Transaction sequencer for the DE10-Lite ADXL345 accelerometer.
//  - After reset, writes the configuration registers once.
//  - Then issues a 6-byte burst read at a fixed rate.
//  - Drives a byte-level SPI engine (accel_spi_byte) through a req/done handshake.
//  - Publishes signed 16-bit X/Y/Z samples with a one-cycle update strobe.
//  - Sits between the SPI engine and the display/arm-control logic.
// PARAMETERS
//  SAMPLE_DIV    25_000_000  clk cycles between sample ticks (1 Hz at 25 MHz); >= 64
//  BW_RATE_VAL   8'h0A       value written to reg 0x2C (BW_RATE)
//  DATA_FMT_VAL  8'h0B       value written to reg 0x31 (DATA_FORMAT: full-res, +/-16 g)
//  PWR_CTL_VAL   8'h08       value written to reg 0x2D (POWER_CTL: measure)
// PORTS
//  clk         in   1   system clock, 25 MHz PLL c0
//  rst         in   1   asynchronous reset, active-high
//  en          in   1   sampling enable; ticks are ignored while low
//  spi_req     out  1   byte transfer request; held until spi_done
//  spi_wdata   out  8   byte to shift out; stable while spi_req is high
//  spi_cs_hold out  1   1 = keep CS_N low after this byte; 0 = release CS_N after it
//  spi_done    in   1   one-cycle pulse: byte finished, spi_rdata valid
//  spi_rdata   in   8   byte shifted in during the transfer
//  data_x      out  16  signed X sample, two's complement
//  data_y      out  16  signed Y sample
//  data_z      out  16  signed Z sample
//  data_update out  1   one-cycle pulse when data_x/y/z change
//  cfg_done    out  1   high once configuration has completed
//  overrun     out  1   sticky; a tick arrived while one was already pending
// BEHAVIOUR
//  Reset values
//  - All outputs are 0.
//  - FSM is in CFG; tick counter, pending flag and byte index are 0.
//  Handshake
//  - spi_req rises with spi_wdata/spi_cs_hold valid.
//  - spi_req drops in the cycle after spi_done. The next request comes no earlier than 1 cycle later.
//  - spi_done while spi_req is low is ignored.
//  Configuration (CFG)
//  - Three 2-byte writes, in order: {8'h2C,BW_RATE_VAL}, {8'h31,DATA_FMT_VAL}, {8'h2D,PWR_CTL_VAL}.
//  - spi_cs_hold is 1 on the address byte and 0 on the data byte.
//  - Then cfg_done is set to 1 and the FSM goes to WAIT.
//  Tick counter
//  - Free-runs from 0 to SAMPLE_DIV-1 and wraps; a tick is the wrap cycle.
//  - While cfg_done=0 or en=0, ticks are dropped.
//  - Otherwise a tick sets pending.
//  - A tick while pending=1 sets overrun, which stays set until rst.
//  - A tick in the same cycle that pending is consumed re-sets pending; overrun is not set.
//  WAIT
//  - pending=1 -> clear pending, go to RD_CMD.
//  RD_CMD
//  - Sends 8'hF2 (read, multi-byte, addr 0x32) with spi_cs_hold=1, then goes to RD_BYTE.
//  RD_BYTE
//  - Sends 6 dummy bytes 8'h00.
//  - spi_cs_hold=1 for bytes 0..4 and 0 for byte 5.
//  - Each spi_rdata goes into shadow[idx], with order X0 X1 Y0 Y1 Z0 Z1.
//  - After byte 5 completes, go to PUBLISH.
//  PUBLISH (1 cycle)
//  - Updates the outputs: data_x={X1,X0}, data_y={Y1,Y0}, data_z={Z1,Z0}.
//  - data_update=1 for this cycle, then go to WAIT.
//  - Outputs change only in PUBLISH, never with partial data.
//  Reset and en
//  - rst mid-burst aborts immediately; the FSM restarts at CFG.
//  - The SPI engine must also be reset by the same rst.
//  - en dropping mid-burst does not abort; the burst completes and publishes.
//  Latency: tick -> data_update = 7 SPI byte times + 3 clk.
// CONFIGURATION
//  ACCEL_ID_CHECK_EN defined
//  - Before CFG the FSM enters ID: sends {8'h80,8'h00} (read DEVID).
//  - rdata==8'hE5 -> go to CFG.
//  - Else set output id_err (1 bit, reset 0, sticky) and retry ID on every tick.
//  - Ticks in this state never set pending or overrun.
//  - cfg_done stays 0 until the ID matches.
//  ACCEL_ID_CHECK_EN undefined
//  - No ID state and no id_err port; reset goes directly to CFG.
// STRUCTURE
//  Package accel_pkg
//  - register address constants: REG_DEVID 8'h00, REG_BW_RATE 8'h2C, REG_PWR_CTL 8'h2D,
//    REG_DATA_FMT 8'h31, REG_DATAX0 8'h32
//  - bit constants: RD_BIT 8'h80, MB_BIT 8'h40; DEVID_VAL 8'hE5
//  - FSM state encoding: ID, CFG, WAIT, RD_CMD, RD_BYTE, PUBLISH
//  Sub-module
//  - One natural sub-module: accel_tick_gen, the SAMPLE_DIV counter with a tick pulse.
//  - The FSM, shadow registers and handshake stay in this module.
// TESTING
//  Bench: SPI engine BFM acks each byte 16 clk after req and returns scripted rdata. Use SAMPLE_DIV=200.
//  1 Config: release rst -> exactly 6 bytes 2C,0A,31,0B,2D,08, with cs_hold 1,0,1,0,1,0
//    -> cfg_done=1; no data_update.
//  2 Sample: en=1; BFM returns 34,12,CD,AB,00,01 -> one data_update pulse
//    with data_x=16'h1234, data_y=16'hABCD, data_z=16'h0100.
//  3 Overrun: BFM delay 40 clk per byte -> overrun=1 after the second tick inside a burst;
//    bursts still back-to-back, each with exactly 7 bytes.
//  4 Enable gating: en=0 for 3 tick periods -> no spi_req after cfg; en=1 -> next tick starts a burst.
//  5 Reset mid-burst: rst during byte 3 -> all outputs 0 in the same cycle;
//    next bytes seen are the 6 config bytes.
//  6 ID (ACCEL_ID_CHECK_EN): DEVID returns 8'hE4 -> id_err=1, cfg_done=0, retry on next tick;
//    then returns 8'hE5 -> config sequence proceeds.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared constants, FSM encoding and a helper for the ADXL345 transaction sequencer.
// Optional DEVID probe is enabled by the ACCEL_ID_CHECK_EN macro (see accel_seq_ctrl).
package accel_pkg;

    localparam logic [7:0] REG_DEVID    = 8'h00;
    localparam logic [7:0] REG_BW_RATE  = 8'h2C;
    localparam logic [7:0] REG_PWR_CTL  = 8'h2D;
    localparam logic [7:0] REG_DATA_FMT = 8'h31;
    localparam logic [7:0] REG_DATAX0   = 8'h32;

    localparam logic [7:0] RD_BIT    = 8'h80;
    localparam logic [7:0] MB_BIT    = 8'h40;
    localparam logic [7:0] DEVID_VAL = 8'hE5;

    // Multi-byte read starting at DATAX0: yields X0 X1 Y0 Y1 Z0 Z1.
    localparam logic [7:0] CMD_RD_DATA = RD_BIT | MB_BIT | REG_DATAX0;
    localparam logic [7:0] CMD_RD_ID   = RD_BIT | REG_DEVID;

    typedef enum logic [2:0] {
        ID      = 3'd0,
        CFG     = 3'd1,
        WAIT    = 3'd2,
        RD_CMD  = 3'd3,
        RD_BYTE = 3'd4,
        PUBLISH = 3'd5
    } state_t;

    // Byte stream of the configuration phase: address/value pairs.
    function automatic logic [7:0] cfg_byte(input logic [2:0] idx, input logic [7:0] bw,
                                            input logic [7:0] df, input logic [7:0] pwr);
        case (idx)
            3'd0:    cfg_byte = REG_BW_RATE;
            3'd1:    cfg_byte = bw;
            3'd2:    cfg_byte = REG_DATA_FMT;
            3'd3:    cfg_byte = df;
            3'd4:    cfg_byte = REG_PWR_CTL;
            default: cfg_byte = pwr;
        endcase
    endfunction

endpackage

// File: rtl/accel_seq_ctrl_if.sv
// Byte-level link between the sequencer (master) and the SPI byte engine (slave).
interface accel_seq_ctrl_if;
    // Handshake: master raises spi_req with spi_wdata/spi_cs_hold valid and holds all three
    // until the slave pulses spi_done for one cycle (spi_rdata valid in that cycle); spi_req
    // drops in the following cycle and stays low for at least one cycle before the next byte.
    // spi_done while spi_req is low is ignored.
    logic       spi_req;
    logic [7:0] spi_wdata;
    logic       spi_cs_hold;
    logic       spi_done;
    logic [7:0] spi_rdata;

    modport master (output spi_req, spi_wdata, spi_cs_hold, input spi_done, spi_rdata);
    modport slave  (input spi_req, spi_wdata, spi_cs_hold, output spi_done, spi_rdata);
endinterface

// File: rtl/accel_tick_gen.sv
// Free-running sample-rate divider; tick is high in the wrap cycle of the counter.
module accel_tick_gen #(
    parameter int SAMPLE_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/accel_seq_ctrl.sv
// ADXL345 sequencer: one-shot register config, then periodic 6-byte XYZ burst reads.
// Define ACCEL_ID_CHECK_EN to probe DEVID before configuring (adds the id_err output).
module accel_seq_ctrl
    import accel_pkg::*;
#(
    parameter int         SAMPLE_DIV   = 25_000_000,
    parameter logic [7:0] BW_RATE_VAL  = 8'h0A,
    parameter logic [7:0] DATA_FMT_VAL = 8'h0B,
    parameter logic [7:0] PWR_CTL_VAL  = 8'h08
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    accel_seq_ctrl_if.master    spi,
    output logic signed [15:0]  data_x,
    output logic signed [15:0]  data_y,
    output logic signed [15:0]  data_z,
    output logic                data_update,
    output logic                cfg_done,
    output logic                overrun,
`ifdef ACCEL_ID_CHECK_EN
    output logic                id_err,
`endif
    output state_t              dbg_state
);

`ifdef ACCEL_ID_CHECK_EN
    localparam state_t START_ST = ID;
`else
    localparam state_t START_ST = CFG;
`endif

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic       pending;
    logic [7:0] shadow [0:5];
    logic       tick;
    logic       id_wait;

    logic       byte_state, byte_last, cs_sel, consume, publish;
    logic [7:0] wdata_sel;
    logic       xfer_done, launch, tick_ok, id_ok;

    accel_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign xfer_done = spi.spi_req & spi.spi_done;
    assign launch    = byte_state & ~spi.spi_req & ~id_wait;
    assign tick_ok   = tick & cfg_done & en;
    assign id_ok     = (spi.spi_rdata == DEVID_VAL);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START_ST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ID:      if (xfer_done && byte_last && id_ok) state_nxt = CFG;
            CFG:     if (xfer_done && byte_last) state_nxt = WAIT;
            WAIT:    if (pending) state_nxt = RD_CMD;
            RD_CMD:  if (xfer_done) state_nxt = RD_BYTE;
            RD_BYTE: if (xfer_done && byte_last) state_nxt = PUBLISH;
            PUBLISH: state_nxt = WAIT;
            default: state_nxt = START_ST;
        endcase
    end

    // Per-state byte selection and the strobes that drive the datapath below.
    always_comb begin
        byte_state = 1'b0;
        byte_last  = 1'b0;
        wdata_sel  = 8'h00;
        cs_sel     = 1'b0;
        consume    = 1'b0;
        publish    = 1'b0;
        case (state)
            ID: begin
                byte_state = 1'b1;
                byte_last  = (idx == 3'd1);
                wdata_sel  = (idx == 3'd0) ? CMD_RD_ID : 8'h00;
                cs_sel     = (idx == 3'd0);
            end
            CFG: begin
                byte_state = 1'b1;
                byte_last  = (idx == 3'd5);
                wdata_sel  = cfg_byte(idx, BW_RATE_VAL, DATA_FMT_VAL, PWR_CTL_VAL);
                cs_sel     = ~idx[0];
            end
            WAIT:    consume = pending;
            RD_CMD: begin
                byte_state = 1'b1;
                byte_last  = 1'b1;
                wdata_sel  = CMD_RD_DATA;
                cs_sel     = 1'b1;
            end
            RD_BYTE: begin
                byte_state = 1'b1;
                byte_last  = (idx == 3'd5);
                cs_sel     = (idx != 3'd5);
            end
            PUBLISH: publish = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi.spi_req     <= 1'b0;
            spi.spi_wdata   <= 8'h00;
            spi.spi_cs_hold <= 1'b0;
            idx             <= 3'd0;
            pending         <= 1'b0;
            overrun         <= 1'b0;
            cfg_done        <= 1'b0;
            data_update     <= 1'b0;
            data_x          <= '0;
            data_y          <= '0;
            data_z          <= '0;
            for (int i = 0; i < 6; i++) shadow[i] <= 8'h00;
        end else begin
            data_update <= publish;
            if (launch) begin
                spi.spi_req     <= 1'b1;
                spi.spi_wdata   <= wdata_sel;
                spi.spi_cs_hold <= cs_sel;
            end else if (xfer_done) begin
                spi.spi_req <= 1'b0;
            end
            if (xfer_done) begin
                idx <= byte_last ? 3'd0 : idx + 3'd1;
            end
            if (xfer_done && state == RD_BYTE) begin
                shadow[idx] <= spi.spi_rdata;
            end
            if (xfer_done && byte_last && state == CFG) begin
                cfg_done <= 1'b1;
            end
            if (publish) begin
                data_x <= {shadow[1], shadow[0]};
                data_y <= {shadow[3], shadow[2]};
                data_z <= {shadow[5], shadow[4]};
            end
            // A tick coinciding with consumption re-arms pending without flagging overrun.
            if (tick_ok) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
            if (tick_ok && pending && !consume) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef ACCEL_ID_CHECK_EN
    // A DEVID mismatch parks the probe until the next tick, then retries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_err  <= 1'b0;
            id_wait <= 1'b0;
        end else if (state == ID && xfer_done && byte_last && !id_ok) begin
            id_err  <= 1'b1;
            id_wait <= 1'b1;
        end else if (id_wait && tick) begin
            id_wait <= 1'b0;
        end
    end
`else
    assign id_wait = 1'b0;
`endif

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Directed bench for accel_seq_ctrl with a scripted SPI byte-engine model.
module tb_accel_seq_ctrl;
    import accel_pkg::*;

    localparam int DIV = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic signed [15:0] data_x, data_y, data_z;
    logic data_update, cfg_done, overrun;
    state_t dbg_state;
`ifdef ACCEL_ID_CHECK_EN
    logic id_err;
`endif

    accel_seq_ctrl_if spi_bus ();

    accel_seq_ctrl #(.SAMPLE_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .spi         (spi_bus),
        .data_x      (data_x),
        .data_y      (data_y),
        .data_z      (data_z),
        .data_update (data_update),
        .cfg_done    (cfg_done),
        .overrun     (overrun),
`ifdef ACCEL_ID_CHECK_EN
        .id_err      (id_err),
`endif
        .dbg_state   (dbg_state)
    );

    always #20 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         bfm_delay = 16;
    int         bfm_cnt   = 0;
    bit         bfm_acked = 1'b0;
    int         upd_cnt   = 0;
    logic [7:0] rdata_q [$];
    logic [7:0] wdata_log [$];
    logic       cs_log [$];

    // SPI engine model: acks each byte bfm_delay cycles after req, logs what was sent.
    always @(negedge clk) begin
        if (rst) begin
            spi_bus.spi_done  = 1'b0;
            spi_bus.spi_rdata = 8'h00;
            bfm_cnt   = 0;
            bfm_acked = 1'b0;
        end else begin
            spi_bus.spi_done = 1'b0;
            if (!spi_bus.spi_req) begin
                bfm_acked = 1'b0;
            end else if (!bfm_acked) begin
                if (bfm_cnt == 0) begin
                    wdata_log.push_back(spi_bus.spi_wdata);
                    cs_log.push_back(spi_bus.spi_cs_hold);
                end
                bfm_cnt++;
                if (bfm_cnt >= bfm_delay) begin
                    spi_bus.spi_done = 1'b1;
                    if (rdata_q.size() > 0) spi_bus.spi_rdata = rdata_q.pop_front();
                    else spi_bus.spi_rdata = 8'h00;
                    bfm_cnt   = 0;
                    bfm_acked = 1'b1;
                end
            end
            if (data_update) upd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wdata_log.delete();
        cs_log.delete();
    endtask

    task automatic wait_cfg(input int budget);
        int n = 0;
        while (!cfg_done && n < budget) begin
            step();
            n++;
        end
        chk("cfg_done_seen", {31'd0, cfg_done}, 32'd1);
    endtask

    task automatic wait_updates(input int target, input int budget, input string tag);
        int n = 0;
        while (upd_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(tag, upd_cnt, target);
    endtask

    task automatic check_cfg_log(input string tag);
        logic [7:0] exp_b [6] = '{8'h2C, 8'h0A, 8'h31, 8'h0B, 8'h2D, 8'h08};
        chk({tag, "_len"}, wdata_log.size(), 6);
        if (wdata_log.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("%s_b%0d", tag, i), {24'd0, wdata_log[i]}, {24'd0, exp_b[i]});
                chk($sformatf("%s_cs%0d", tag, i), {31'd0, cs_log[i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic check_bursts(input int nbursts, input string tag);
        chk({tag, "_len"}, wdata_log.size(), 7 * nbursts);
        if (wdata_log.size() == 7 * nbursts) begin
            for (int b = 0; b < nbursts; b++) begin
                for (int k = 0; k < 7; k++) begin
                    chk($sformatf("%s_%0d_b%0d", tag, b, k), {24'd0, wdata_log[7*b+k]},
                        (k == 0) ? 32'hF2 : 32'h00);
                    chk($sformatf("%s_%0d_cs%0d", tag, b, k), {31'd0, cs_log[7*b+k]},
                        (k == 6) ? 32'd0 : 32'd1);
                end
            end
        end
    endtask

`ifdef ACCEL_ID_CHECK_EN
    task automatic pop_id_bytes(input string tag);
        chk({tag, "_idlen"}, wdata_log.size(), 8);
        if (wdata_log.size() >= 2) begin
            chk({tag, "_id0"}, {24'd0, wdata_log.pop_front()}, 32'h80);
            chk({tag, "_id1"}, {24'd0, wdata_log.pop_front()}, 32'h00);
            void'(cs_log.pop_front());
            void'(cs_log.pop_front());
        end
    endtask
`endif

    initial begin
        int n;
        state_t start_st;
`ifdef ACCEL_ID_CHECK_EN
        start_st = ID;
`else
        start_st = CFG;
`endif
        // Reset state
        repeat (3) step();
        chk("rst_req", {31'd0, spi_bus.spi_req}, 32'd0);
        chk("rst_wdata", {24'd0, spi_bus.spi_wdata}, 32'd0);
        chk("rst_cs", {31'd0, spi_bus.spi_cs_hold}, 32'd0);
        chk("rst_x", {16'd0, data_x}, 32'd0);
        chk("rst_y", {16'd0, data_y}, 32'd0);
        chk("rst_z", {16'd0, data_z}, 32'd0);
        chk("rst_upd", {31'd0, data_update}, 32'd0);
        chk("rst_cfg", {31'd0, cfg_done}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, {29'd0, start_st});

`ifdef ACCEL_ID_CHECK_EN
        // DEVID mismatch, then match on the tick-driven retry
        rdata_q = '{8'h00, 8'hE4};
        rst = 1'b0;
        n = 0;
        while (!id_err && n < 200) begin
            step();
            n++;
        end
        chk("id_err_set", {31'd0, id_err}, 32'd1);
        chk("id_cfg_low", {31'd0, cfg_done}, 32'd0);
        chk("id_try_len", wdata_log.size(), 2);
        clear_logs();
        rdata_q = '{8'h00, 8'hE5};
        wait_cfg(800);
        pop_id_bytes("id_retry");
        chk("id_err_sticky", {31'd0, id_err}, 32'd1);
`else
        rst = 1'b0;
        wait_cfg(400);
`endif
        // Configuration stream
        check_cfg_log("cfg");
        chk("cfg_no_upd", upd_cnt, 0);

        // Sample publish
        clear_logs();
        upd_cnt = 0;
        rdata_q = '{8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h01};
        en = 1'b1;
        wait_updates(1, 600, "smp_upd");
        en = 1'b0;
        chk("smp_x", {16'd0, data_x}, 32'h1234);
        chk("smp_y", {16'd0, data_y}, 32'hABCD);
        chk("smp_z", {16'd0, data_z}, 32'h0100);
        check_bursts(1, "smp");
        repeat (20) step();
        chk("smp_one_pulse", upd_cnt, 1);

        // Enable gating
        clear_logs();
        repeat (3 * DIV) step();
        chk("gate_no_bytes", wdata_log.size(), 0);
        chk("gate_req_low", {31'd0, spi_bus.spi_req}, 32'd0);
        en = 1'b1;
        n = 0;
        while (!spi_bus.spi_req && n < DIV + 20) begin
            step();
            n++;
        end
        chk("gate_req_after_en", {31'd0, spi_bus.spi_req}, 32'd1);
        chk("gate_cmd", {24'd0, spi_bus.spi_wdata}, 32'hF2);
        upd_cnt = 0;
        wait_updates(1, 400, "gate_upd");
        chk("gate_x_zero", {16'd0, data_x}, 32'h0000);
        chk("gate_no_ovr", {31'd0, overrun}, 32'd0);

        // Overrun with slow engine: bursts longer than a tick period
        clear_logs();
        upd_cnt = 0;
        bfm_delay = 40;
        for (int b = 0; b < 3; b++) begin
            rdata_q.push_back(8'h00); rdata_q.push_back(8'h55); rdata_q.push_back(8'hAA);
            rdata_q.push_back(8'h11); rdata_q.push_back(8'h22); rdata_q.push_back(8'h33);
            rdata_q.push_back(8'h44);
        end
        wait_updates(3, 2000, "ovr_upd");
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_x", {16'd0, data_x}, 32'hAA55);
        chk("ovr_y", {16'd0, data_y}, 32'h2211);
        chk("ovr_z", {16'd0, data_z}, 32'h4433);
        check_bursts(3, "ovr");

        // Reset in the middle of the next burst
        clear_logs();
        bfm_delay = 16;
        n = 0;
        while (wdata_log.size() < 4 && n < 400) begin
            step();
            n++;
        end
        chk("mid_reached_b3", wdata_log.size(), 4);
        #5;
        rst = 1'b1;
        en = 1'b0;
        #1;
        chk("mid_req", {31'd0, spi_bus.spi_req}, 32'd0);
        chk("mid_x", {16'd0, data_x}, 32'd0);
        chk("mid_y", {16'd0, data_y}, 32'd0);
        chk("mid_z", {16'd0, data_z}, 32'd0);
        chk("mid_ovr", {31'd0, overrun}, 32'd0);
        chk("mid_cfg", {31'd0, cfg_done}, 32'd0);
        chk("mid_state", {29'd0, dbg_state}, {29'd0, start_st});
        repeat (3) step();
        clear_logs();
        rdata_q.delete();
        upd_cnt = 0;
`ifdef ACCEL_ID_CHECK_EN
        rdata_q = '{8'h00, 8'hE5};
        chk("mid_id_err_clr", {31'd0, id_err}, 32'd0);
`endif
        rst = 1'b0;
        wait_cfg(400);
`ifdef ACCEL_ID_CHECK_EN
        pop_id_bytes("mid");
`endif
        check_cfg_log("mid_cfg");
        chk("mid_no_upd", upd_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
